disp_scheduler: RTL and testbench

Time-shares the 4-digit seven-segment display between three requesters and a background value. It sits between the producers (RNG result, score, status codes) and the display driver. It accepts one request at a time with a req/ack handshake and holds the latched value on the display for a fixed number of scan ticks. Grants rotate round-robin, and the display falls back to the background value when no request is pending.

---
 rtl/disp_scheduler.sv | 107 ++++++++++
 tb/tb_disp_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : disp_scheduler
// Description : Round-robin time-sharing of the 4-digit display between three
//               requesters, falling back to a background value when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scheduler #(
    parameter int unsigned HOLD_TICKS = 1000
) (
    input  logic        CLK500Hz,
    input  logic        rstn,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] bg_data,
    output logic [2:0]  ack,
    output logic [15:0] disp_data,
    output logic [1:0]  disp_src,
    output logic        busy
);

    localparam logic [15:0] C_LAST_TICK = 16'(HOLD_TICKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_last;
    logic [15:0] r_hold;
    logic [15:0] r_disp_data;
    logic [1:0]  r_disp_src;
    logic [2:0]  r_ack;
    logic        r_busy;

    logic [1:0]  w_win;
    logic [15:0] w_win_data;
    logic        w_any;
    logic        w_decide;

    assign w_any    = |req;
    assign w_decide = (r_state == ST_IDLE) || (r_cnt == C_LAST_TICK);

    // Scan starts one past the last winner, wrapping over the three requesters.
    always_comb begin
        w_win = 2'd0;
        case (r_last)
            2'd0:    w_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        w_win_data = data0;
        case (w_win)
            2'd1:    w_win_data = data1;
            2'd2:    w_win_data = data2;
            default: w_win_data = data0;
        endcase
    end

    always_ff @(posedge CLK500Hz or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_last      <= 2'd2;
            r_hold      <= 16'h0000;
            r_disp_data <= 16'h0000;
            r_disp_src  <= 2'd0;
            r_ack       <= 3'b000;
            r_busy      <= 1'b0;
        end else begin
            r_ack <= 3'b000;
            if (r_state == ST_SHOW && !w_decide) begin
                r_cnt       <= r_cnt + 16'd1;
                r_disp_data <= r_hold;
            end else if (w_any) begin
                r_state     <= ST_SHOW;
                r_hold      <= w_win_data;
                r_disp_data <= w_win_data;
                r_disp_src  <= w_win + 2'd1;
                r_ack       <= 3'b001 << w_win;
                r_last      <= w_win;
                r_cnt       <= 16'd0;
                r_busy      <= 1'b1;
            end else begin
                r_state     <= ST_IDLE;
                r_cnt       <= 16'd0;
                r_disp_data <= bg_data;
                r_disp_src  <= 2'd0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign ack       = r_ack;
    assign disp_data = r_disp_data;
    assign disp_src  = r_disp_src;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_disp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_disp_scheduler
// Description : Scoreboard bench for disp_scheduler against a countdown model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scheduler;

    localparam int C_HOLD = 4;

    logic        CLK500Hz = 1'b0;
    logic        rstn     = 1'b0;
    logic [2:0]  req      = 3'b000;
    logic [15:0] data0    = 16'h0000;
    logic [15:0] data1    = 16'h0000;
    logic [15:0] data2    = 16'h0000;
    logic [15:0] bg_data  = 16'h1234;
    logic [2:0]  ack;
    logic [15:0] disp_data;
    logic [1:0]  disp_src;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [2:0]  ack;
        logic [15:0] data;
        logic [1:0]  src;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    disp_scheduler #(.HOLD_TICKS(C_HOLD)) dut (
        .CLK500Hz  (CLK500Hz),
        .rstn      (rstn),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .bg_data   (bg_data),
        .ack       (ack),
        .disp_data (disp_data),
        .disp_src  (disp_src),
        .busy      (busy)
    );

    always #5 CLK500Hz = ~CLK500Hz;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: a shown value occupies the display for C_HOLD edges, counted down.
    bit          m_show = 1'b0;
    int          m_left = 0;
    int          m_last = 2;
    logic [15:0] m_hold = 16'h0000;
    exp_t        m_out  = '0;

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge CLK500Hz) begin
        if (!rstn) begin
            m_show = 1'b0; m_left = 0; m_last = 2; m_hold = 16'h0000;
            m_out  = '0;
        end else begin
            int w;
            m_out.ack = 3'b000;
            if (m_show && m_left > 1) begin
                m_left--;
                m_out.data = m_hold;
            end else begin
                w = pick(req, m_last);
                if (w >= 0) begin
                    m_show = 1'b1;
                    m_left = C_HOLD;
                    m_last = w;
                    m_hold = (w == 0) ? data0 : (w == 1) ? data1 : data2;
                    m_out.data = m_hold;
                    m_out.src  = 2'(w + 1);
                    m_out.ack  = 3'(1 << w);
                    m_out.busy = 1'b1;
                end else begin
                    m_show = 1'b0;
                    m_out.data = bg_data;
                    m_out.src  = 2'd0;
                    m_out.busy = 1'b0;
                end
            end
        end
        exp_q.push_back(m_out);
    end

    always @(posedge CLK500Hz) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("ack",       16'(ack),      16'(e.ack));
            chk("disp_data", disp_data,     e.data);
            chk("disp_src",  16'(disp_src), 16'(e.src));
            chk("busy",      16'(busy),     16'(e.busy));
        end
    end

    // Requesters drop req after seeing ack and raise it when asked by the mask.
    task automatic cycle(input logic [2:0] raise_mask);
        @(negedge CLK500Hz);
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) req[i] = 1'b0;
            else if (raise_mask[i]) req[i] = 1'b1;
        end
    endtask

    task automatic reset_now();
        @(negedge CLK500Hz);
        rstn = 1'b0;
        #1;
        chk("rst_disp_data", disp_data, 16'h0000);
        chk("rst_busy",      16'(busy), 16'h0000);
        chk("rst_ack",       16'(ack),  16'h0000);
        chk("rst_src",       16'(disp_src), 16'h0000);
        @(negedge CLK500Hz);
        @(negedge CLK500Hz);
        rstn = 1'b1;
    endtask

    initial begin
        // Reset and background
        repeat (2) @(negedge CLK500Hz);
        rstn = 1'b1;
        repeat (3) cycle(3'b000);

        // Single request with data changed mid-hold
        data1 = 16'hBEEF;
        cycle(3'b010);
        cycle(3'b000);
        cycle(3'b000);
        data1 = 16'h0000;
        repeat (5) cycle(3'b000);

        // All three requesting continuously
        data0 = 16'hAAAA; data1 = 16'hBBBB; data2 = 16'hCCCC;
        repeat (18) cycle(3'b111);
        repeat (6) cycle(3'b000);

        // Requester 0 served, then contention with 2
        cycle(3'b001);
        repeat (12) cycle(3'b101);
        repeat (6) cycle(3'b000);

        // Reset in the middle of a hold with req[2] kept high
        cycle(3'b100);
        cycle(3'b000);
        req[2] = 1'b1;
        reset_now();
        repeat (8) cycle(3'b000);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
            if ($urandom_range(0, 5) == 0) bg_data = 16'($urandom);
            if ($urandom_range(0, 199) == 0) reset_now();
            else cycle(3'($urandom) & 3'($urandom));
        end

        req = 3'b000;
        repeat (8) @(negedge CLK500Hz);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
